// File: rtl/multiplicador_suma_7bits_if.sv
// Start/done handshake and operand/result bus for the shift-and-add
// multiplier-accumulator (producto = cociente * divisor + resto).
interface multiplicador_suma_7bits_if #(
  parameter int WIDTH = 7
);
  logic                 start;
  logic [WIDTH-1:0]     cociente;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     resto;
  logic [2*WIDTH-1:0]   producto;
  logic                 done;
  logic                 busy;

  modport master (
    output start,
    output cociente,
    output divisor,
    output resto,
    input  producto,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  cociente,
    input  divisor,
    input  resto,
    output producto,
    output done,
    output busy
  );
endinterface

// File: rtl/multiplicador_suma_7bits.sv
// Sequential shift-and-add multiplier-accumulator: rebuilds a dividend from
// the restoring divider's quotient/remainder, one multiplier bit per cycle.
module multiplicador_suma_7bits #(
  parameter int WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  multiplicador_suma_7bits_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_producto;
  logic                 r_done;
  logic                 r_busy;

  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;

  // Accumulator after this iteration's conditional add; also the final result
  assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_producto <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.cociente};
            r_mplier <= bus.divisor;
            r_acc    <= {{WIDTH{1'b0}}, bus.resto};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_producto <= w_sum;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.producto = r_producto;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_multiplicador_suma_7bits.sv
// Self-checking bench for multiplicador_suma_7bits: directed scenarios plus
// randomized operands checked against plain-arithmetic expectations.
module tb_multiplicador_suma_7bits;
  localparam int WIDTH = 7;
  localparam int LAT   = WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  multiplicador_suma_7bits_if #(.WIDTH(WIDTH)) bus ();

  multiplicador_suma_7bits #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Present operands with start for one edge (edge 0), then scramble inputs.
  task automatic drive_start(input int c, input int d, input int r);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.cociente = WIDTH'(c);
    bus.divisor  = WIDTH'(d);
    bus.resto    = WIDTH'(r);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.cociente = WIDTH'($urandom);
    bus.divisor  = WIDTH'($urandom);
    bus.resto    = WIDTH'($urandom);
  endtask

  // Edges after edge 0 until done is seen; -1 when the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = e;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.producto !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: producto=%0d done=%0b busy=%0b, required 0/0/0",
               bus.producto, bus.done, bus.busy);
    end
    bus.start = 1'b0; bus.cociente = '0; bus.divisor = '0; bus.resto = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int bad_done = 0;
    drive_start(3, 2, 1);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_edge0: busy=%0b required 1", bus.busy);
    end
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk);
      #1;
      if (bus.done !== (e == LAT)) bad_done++;
      if (e < LAT && bus.producto !== '0) bad_done++;
    end
    n_tests++;
    if (bad_done != 0) begin
      n_fail++;
      $display("FAIL basic_timing: %0d bad cycles, required 0", bad_done);
    end
    n_tests++;
    if (bus.producto !== 14'd7 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: producto=%0d busy=%0b, required 7/0",
               bus.producto, bus.busy);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%0b one edge later, required 0", bus.done);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.producto !== 14'd7) begin
      n_fail++;
      $display("FAIL basic_hold: producto=%0d, required 7", bus.producto);
    end
  endtask

  // Operands taken from an ideal divider of A by B, result must give A back.
  task automatic test_roundtrip();
    int a_tab [4] = '{50, 99, 127, 64};
    int b_tab [4] = '{7, 10, 1, 127};
    int q, r, lat;
    for (int i = 0; i < 4; i++) begin
      q = a_tab[i] / b_tab[i];
      r = a_tab[i] % b_tab[i];
      drive_start(q, b_tab[i], r);
      wait_done(lat);
      n_tests++;
      if (lat != LAT || int'(bus.producto) != a_tab[i]) begin
        n_fail++;
        $display("FAIL roundtrip_%0d: producto=%0d latency=%0d, required %0d latency %0d",
                 a_tab[i], bus.producto, lat, a_tab[i], LAT);
      end
    end
  endtask

  task automatic test_boundary();
    int c_tab [4] = '{127, 127, 0, 0};
    int d_tab [4] = '{127, 0, 99, 0};
    int r_tab [4] = '{127, 5, 17, 0};
    int lat, expv;
    for (int i = 0; i < 4; i++) begin
      expv = c_tab[i] * d_tab[i] + r_tab[i];
      drive_start(c_tab[i], d_tab[i], r_tab[i]);
      wait_done(lat);
      n_tests++;
      if (lat != LAT || int'(bus.producto) != expv) begin
        n_fail++;
        $display("FAIL boundary_%0d: producto=%0d latency=%0d, required %0d latency %0d",
                 i, bus.producto, lat, expv, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    drive_start(12, 11, 3);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.cociente = 7'd1; bus.divisor = 7'd1; bus.resto = 7'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 4; e <= LAT; e++) begin
      @(posedge clk);
      #1;
      if (bus.done !== (e == LAT)) bad++;
    end
    n_tests++;
    if (bad != 0 || bus.producto !== 14'd135) begin
      n_fail++;
      $display("FAIL ignore_start: producto=%0d bad_cycles=%0d, required 135/0",
               bus.producto, bad);
    end
    bus.start = 1'b1; bus.cociente = 7'd4; bus.divisor = 7'd5; bus.resto = 7'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%0b done=%0b, required 1/0", bus.busy, bus.done);
    end
    bad = 0;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk);
      #1;
      if (bus.done !== (e == LAT)) bad++;
      if (e < LAT && bus.producto !== 14'd135) bad++;
    end
    n_tests++;
    if (bad != 0 || bus.producto !== 14'd26) begin
      n_fail++;
      $display("FAIL b2b_result: producto=%0d bad_cycles=%0d, required 26/0",
               bus.producto, bad);
    end
  endtask

  task automatic test_continuous_start();
    int dones = 0;
    int first = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.cociente = 7'd9; bus.divisor = 7'd10; bus.resto = 7'd9;
    for (int e = 0; e <= 2*(LAT+1); e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (first < 0) first = e;
      end
    end
    bus.start = 1'b0;
    n_tests++;
    if (dones != 2 || first != LAT || bus.producto !== 14'd99) begin
      n_fail++;
      $display("FAIL continuous_start: dones=%0d first=%0d producto=%0d, required 2/%0d/99",
               dones, first, bus.producto, LAT);
    end
    repeat (LAT + 2) @(posedge clk);
  endtask

  task automatic test_async_reset();
    int lat;
    drive_start(100, 100, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.producto !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: producto=%0d busy=%0b done=%0b, required 0/0/0",
               bus.producto, bus.busy, bus.done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_done(lat);
    n_tests++;
    if (lat != -1) begin
      n_fail++;
      $display("FAIL no_done_after_abort: done seen at edge %0d, required none", lat);
    end
    drive_start(5, 5, 0);
    wait_done(lat);
    n_tests++;
    if (lat != LAT || bus.producto !== 14'd25) begin
      n_fail++;
      $display("FAIL after_reset: producto=%0d latency=%0d, required 25 latency %0d",
               bus.producto, lat, LAT);
    end
  endtask

  task automatic test_random();
    int c, d, r, lat, expv;
    for (int i = 0; i < 24; i++) begin
      c = $urandom_range(0, 127);
      d = $urandom_range(0, 127);
      r = $urandom_range(0, 127);
      expv = c * d + r;
      drive_start(c, d, r);
      wait_done(lat);
      n_tests++;
      if (lat != LAT || int'(bus.producto) != expv) begin
        n_fail++;
        $display("FAIL random_%0d (%0d*%0d+%0d): producto=%0d latency=%0d, required %0d latency %0d",
                 i, c, d, r, bus.producto, lat, expv, LAT);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cociente = '0; bus.divisor = '0; bus.resto = '0;
    test_reset();
    test_basic();
    test_roundtrip();
    test_boundary();
    test_back_to_back();
    test_continuous_start();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplicador_suma_7bits.md
Name: multiplicador_suma_7bits

Overview:
Sequential shift-and-add multiplier-accumulator that performs the inverse of the restoring divider: it computes producto = cociente * divisor + resto. It takes the divider's outputs plus its divisor and reconstructs the dividend. The block closes the loop around divisor_restoring_7bits in self-checking benches and in the datapath's round-trip check. It uses the same start/done handshake as the divider.

Parameters:
WIDTH, 7, operand width in bits; producto is 2*WIDTH bits wide.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; clears all state immediately when low.
start  input  1  request pulse; sampled on the rising edge of clk only while idle.
cociente  input  WIDTH  multiplicand, unsigned.
divisor  input  WIDTH  multiplier, unsigned.
resto  input  WIDTH  addend, unsigned; preloads the accumulator.
producto  output  2*WIDTH  result cociente*divisor+resto; registered; held until the next completion.
done  output  1  one-cycle completion pulse, registered.
busy  output  1  high while a computation is in progress.

Behaviour:
- Reset (rst low, asynchronous) drives these values:
  - producto = 0, done = 0, busy = 0.
  - FSM = IDLE; all internal registers cleared.
  - This applies at any time, including mid-computation. The aborted result is discarded and no done is produced.
- FSM states are IDLE and CALC.
- IDLE, on an edge with start=1:
  - Latch the operands: mcand = zero-extended cociente (2*WIDTH bits), mplier = divisor, acc = zero-extended resto, cnt = 0.
  - Go to CALC; busy = 1 from this edge.
  - Input changes after this edge have no effect on the running computation.
- CALC, each edge:
  - If mplier[0] = 1, acc = acc + mcand.
  - mcand shifts left 1; mplier shifts right 1 (logical); cnt increments.
  - On the edge where cnt == WIDTH-1 (the WIDTH-th iteration):
    - producto is loaded with the final acc value, including this iteration's add.
    - done = 1 for exactly one cycle; busy = 0; FSM returns to IDLE.
- Latency: the start-sampling edge is edge 0. producto and done update on edge WIDTH, which is edge 7 for the default width. done is high from edge WIDTH to edge WIDTH+1.
- Throughput: one operation per WIDTH+1 cycles. start may be high in the same cycle done is high; it is accepted at edge WIDTH+1 (back-to-back operation).
- start while busy is ignored: no restart and no queuing. The running result is unaffected.
- start held high continuously starts a new operation every time the FSM is in IDLE.
- Width rules:
  - All arithmetic is unsigned.
  - The maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, which is less than 2^(2W), so no overflow is possible. No saturation or carry output is needed.
  - The acc adder is 2*WIDTH bits.
- Boundary values:
  - divisor = 0 gives producto = resto.
  - cociente = 0 gives producto = resto.
  - All-zero operands still take the full latency and still pulse done.
- producto holds its value between completions. It does not change at start; it changes only on the completion edge.

Test Plan:
- Release reset, then start with cociente=3, divisor=2, resto=1 -> at edge 7 after start: producto=7, done high 1 cycle, busy low; producto still 7 four cycles later.
- cociente=7, divisor=7, resto=1 -> producto=50. Then cociente=9, divisor=10, resto=9 -> producto=99. Each pair is driven from the divider's (Q,R) outputs for A=50 B=7 and A=99 B=10, and the round trip is checked for equality with A.
- cociente=127, divisor=127, resto=127 -> producto=16256 (max, no overflow). Then cociente=127, divisor=0, resto=5 -> producto=5 after the full 7 cycles.
- Start a computation with 12*11+3. Assert start again at cycle 3 with different operands -> ignored, producto=135 at edge 7. Assert start together with done -> second operation accepted; its done arrives 7 edges later.
- Start 100*100+0. Pull rst low at cycle 4 -> producto=0, busy=0, done=0 immediately and asynchronously; no done pulse follows. After release, a new 5*5+0 gives 25.
